coin_classifier: RTL and testbench

//  Front-end stage feeding the vending FSM. Conditions the raw optical coin-gate line:

---
 rtl/coin_pkg.sv | 34 +++
 rtl/coin_debouncer.sv | 53 +++++
 rtl/coin_classifier.sv | 118 +++++++++++
 tb/tb_coin_classifier.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared definitions for the coin-gate front end.
//   - FSM state encodings for coin_classifier
//   - coin type codes carried on sensor_2
//   - default timing windows, in clock cycles of blocked beam
//   - in_window(): inclusive range test used by the classifier
package coin_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_MEASURE  = 2'd1;
  localparam logic [1:0] ST_CLASSIFY = 2'd2;
  localparam logic [1:0] ST_JAM      = 2'd3;

  // Coin type codes as presented on sensor_2
  localparam logic COIN_5  = 1'b0;
  localparam logic COIN_10 = 1'b1;

  // Default conditioning and classification windows
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_CNT_W           = 16;
  localparam int DEF_MIN_5           = 100;
  localparam int DEF_MAX_5           = 299;
  localparam int DEF_MIN_10          = 300;
  localparam int DEF_MAX_10          = 600;
  localparam int DEF_JAM_CYCLES      = 2000;

  // Inclusive window test: lo <= value <= hi
  function automatic logic in_window(input logic [31:0] value,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/coin_debouncer.sv
// Synchroniser plus stable-count filter for the raw coin-gate level.
//   clock    in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   din      in  raw asynchronous level (bouncy)
//   dout     out debounced level; follows the synchronised input once it has
//                differed from dout for DEBOUNCE_CYCLES consecutive cycles
module coin_debouncer
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            meta;
  logic            synced;
  logic [DB_W-1:0] stable_cnt;

  // Two-flop synchroniser; meta may go metastable, synced is safe to use.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b0;
      synced <= 1'b0;
    end else begin
      meta   <= din;
      synced <= meta;
    end
  end

  // Count consecutive cycles in which synced disagrees with dout. Any cycle
  // of agreement restarts the count; the last disagreeing cycle flips dout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stable_cnt <= '0;
      dout       <= 1'b0;
    end else if (synced == dout) begin
      stable_cnt <= '0;
    end else if (stable_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_cnt <= '0;
      dout       <= synced;
    end else begin
      stable_cnt <= stable_cnt + DB_W'(1);
    end
  end

endmodule

// File: rtl/coin_classifier.sv
// Coin-gate front end for the vending FSM: conditions the optical gate line,
// times how long the beam stays blocked and classifies the coin.
//   clock      in  system clock, rising edge
//   reset_n    in  asynchronous active-low reset
//   coin_raw   in  raw gate level, 1 = beam blocked (asynchronous, bouncy)
//   accept_en  in  1 = credits accepted, 0 = downstream busy
//   sensor_1   out one-cycle strobe: valid coin credited
//   sensor_2   out coin type while sensor_1=1 (1 = 10, 0 = 5), else 0
//   reject     out one-cycle strobe: out-of-window or refused coin
//   jam        out level: beam blocked >= JAM_CYCLES, held until gate clears
module coin_classifier
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int MIN_5           = DEF_MIN_5,
  parameter int MAX_5           = DEF_MAX_5,
  parameter int MIN_10          = DEF_MIN_10,
  parameter int MAX_10          = DEF_MAX_10,
  parameter int JAM_CYCLES      = DEF_JAM_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic coin_raw,
  input  logic accept_en,
  output logic sensor_1,
  output logic sensor_2,
  output logic reject,
  output logic jam
);

  logic             coin_db;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             hit_5;
  logic             hit_10;

  coin_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (coin_raw),
    .dout    (coin_db)
  );

  // Windows are disjoint, so at most one of these is set.
  assign hit_5  = in_window(32'(cnt), 32'(MIN_5),  32'(MAX_5));
  assign hit_10 = in_window(32'(cnt), 32'(MIN_10), 32'(MAX_10));

  // cnt holds the number of cycles coin_db has been high. It saturates at
  // JAM_CYCLES by leaving MEASURE, so it can never wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      sensor_1 <= 1'b0;
      sensor_2 <= 1'b0;
      reject   <= 1'b0;
      jam      <= 1'b0;
    end else begin
      // Strobes are one cycle wide unless CLASSIFY sets them below.
      sensor_1 <= 1'b0;
      sensor_2 <= 1'b0;
      reject   <= 1'b0;

      case (state)
        ST_IDLE: begin
          // coin_db is always low on entry to IDLE, so a high level here is
          // a fresh rising edge. The first blocked cycle is already elapsed.
          if (coin_db) begin
            state <= ST_MEASURE;
            cnt   <= CNT_W'(1);
          end else begin
            cnt <= '0;
          end
        end

        ST_MEASURE: begin
          if (!coin_db) begin
            state <= ST_CLASSIFY;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(JAM_CYCLES - 1)) begin
              state <= ST_JAM;
            end
          end
        end

        ST_CLASSIFY: begin
          state <= ST_IDLE;
          if ((hit_5 || hit_10) && accept_en) begin
            sensor_1 <= 1'b1;
            sensor_2 <= hit_10 ? COIN_10 : COIN_5;
          end else begin
            // Out-of-window coins and refused coins are both rejected.
            reject <= 1'b1;
          end
        end

        ST_JAM: begin
          // A jammed coin is never credited or rejected, only flagged.
          if (!coin_db) begin
            state <= ST_IDLE;
            jam   <= 1'b0;
          end else begin
            jam <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_classifier.sv
// Directed bench for coin_classifier at default parameters.
module tb_coin_classifier;

  logic clock     = 1'b0;
  logic reset_n   = 1'b0;
  logic coin_raw  = 1'b0;
  logic accept_en = 1'b1;
  logic sensor_1;
  logic sensor_2;
  logic reject;
  logic jam;

  coin_classifier dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .coin_raw  (coin_raw),
    .accept_en (accept_en),
    .sensor_1  (sensor_1),
    .sensor_2  (sensor_2),
    .reject    (reject),
    .jam       (jam)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Cycle counter and output event counters, all sampled on the falling edge.
  int unsigned cyc         = 0;
  int unsigned fall_cyc    = 0;
  int unsigned last_s1_cyc = 0;
  int          s1_n        = 0;
  int          c10_n       = 0;
  int          rej_n       = 0;
  int          both_n      = 0;
  int          jam_n       = 0;
  int          stray_s2_n  = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (sensor_1) begin
      s1_n        <= s1_n + 1;
      last_s1_cyc <= cyc;
    end
    if (sensor_1 && sensor_2) c10_n      <= c10_n + 1;
    if (!sensor_1 && sensor_2) stray_s2_n <= stray_s2_n + 1;
    if (reject)               rej_n      <= rej_n + 1;
    if (sensor_1 && reject)   both_n     <= both_n + 1;
    if (jam)                  jam_n      <= jam_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Hold coin_raw high for exactly len rising edges, then drop it.
  task automatic pulse(input int len);
    @(negedge clock);
    coin_raw = 1'b1;
    repeat (len) @(negedge clock);
    coin_raw = 1'b0;
    fall_cyc = cyc;
  endtask

  // One clean coin, then a quiet window long enough for the strobe.
  task automatic run_coin(input string tag, input int len,
                          input int e_s1, input int e_c10, input int e_rej);
    int s1_0, c10_0, rej_0, both_0, jam_0, stray_0;
    s1_0 = s1_n; c10_0 = c10_n; rej_0 = rej_n;
    both_0 = both_n; jam_0 = jam_n; stray_0 = stray_s2_n;
    pulse(len);
    repeat (40) @(negedge clock);
    check({tag, "_credits"}, s1_n - s1_0, e_s1);
    check({tag, "_type10"},  c10_n - c10_0, e_c10);
    check({tag, "_rejects"}, rej_n - rej_0, e_rej);
    check({tag, "_exclusive"}, (both_n - both_0) + (stray_s2_n - stray_0) + (jam_n - jam_0), 0);
  endtask

  initial begin
    int s1_0, rej_0, jam_0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_sensor_1", 32'(sensor_1), 0);
    check("rst_sensor_2", 32'(sensor_2), 0);
    check("rst_reject",   32'(reject),   0);
    check("rst_jam",      32'(jam),      0);
    reset_n = 1'b1;
    repeat (5) @(negedge clock);

    // Clean coins and window boundaries
    run_coin("coin200", 200, 1, 0, 0);
    run_coin("coin400", 400, 1, 1, 0);
    check("latency400", last_s1_cyc - fall_cyc, 20);
    run_coin("coin50",  50,  0, 0, 1);
    run_coin("coin99",  99,  0, 0, 1);
    run_coin("coin100", 100, 1, 0, 0);
    run_coin("coin299", 299, 1, 0, 0);
    run_coin("coin300", 300, 1, 1, 0);
    run_coin("coin600", 600, 1, 1, 0);
    run_coin("coin601", 601, 0, 0, 1);

    // Glitches of 1..15 cycles must never reach the debounced level
    s1_0 = s1_n; rej_0 = rej_n;
    for (int g = 1; g <= 15; g++) begin
      @(negedge clock);
      coin_raw = 1'b1;
      repeat (g) @(negedge clock);
      coin_raw = 1'b0;
      repeat (20) @(negedge clock);
    end
    repeat (40) @(negedge clock);
    check("glitch_credits", s1_n - s1_0, 0);
    check("glitch_rejects", rej_n - rej_0, 0);

    // 200-cycle coin with 5-cycle bounce on each edge: one credit5
    s1_0 = s1_n; rej_0 = rej_n;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      coin_raw = (i % 2 == 0);
    end
    repeat (200) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      coin_raw = (i % 2 == 1);
      @(negedge clock);
    end
    coin_raw = 1'b0;
    repeat (40) @(negedge clock);
    check("bounce_credits", s1_n - s1_0, 1);
    check("bounce_rejects", rej_n - rej_0, 0);

    // Jam: 2500-cycle block, jam high from measured cycle 2000 to release
    s1_0 = s1_n; rej_0 = rej_n; jam_0 = jam_n;
    @(negedge clock);
    coin_raw = 1'b1;
    repeat (2400) @(negedge clock);
    check("jam_level", 32'(jam), 1);
    repeat (100) @(negedge clock);
    coin_raw = 1'b0;
    repeat (40) @(negedge clock);
    check("jam_cycles",  jam_n - jam_0, 500);
    check("jam_cleared", 32'(jam), 0);
    check("jam_credits", s1_n - s1_0, 0);
    check("jam_rejects", rej_n - rej_0, 0);

    // Refused coin while downstream is busy
    accept_en = 1'b0;
    run_coin("refused400", 400, 0, 0, 1);
    accept_en = 1'b1;

    // Reset in mid-MEASURE with the gate clearing during reset
    s1_0 = s1_n; rej_0 = rej_n;
    @(negedge clock);
    coin_raw = 1'b1;
    repeat (150) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({sensor_1, sensor_2, reject, jam}), 0);
    coin_raw = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (60) @(negedge clock);
    check("rst_mid_credits", s1_n - s1_0, 0);
    check("rst_mid_rejects", rej_n - rej_0, 0);

    // Reset during a jam, gate still blocked 50 cycles after release:
    // jam drops at once, the remainder is measured as a short coin
    @(negedge clock);
    coin_raw = 1'b1;
    repeat (2200) @(negedge clock);
    check("rst_jam_before", 32'(jam), 1);
    reset_n = 1'b0;
    #1;
    check("rst_jam_async", 32'(jam), 0);
    s1_0 = s1_n; rej_0 = rej_n;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (50) @(negedge clock);
    coin_raw = 1'b0;
    repeat (40) @(negedge clock);
    check("rst_jam_credits", s1_n - s1_0, 0);
    check("rst_jam_rejects", rej_n - rej_0, 1);
    check("rst_jam_level",   32'(jam), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
